// File: rtl/core_pkg.sv
// Shared RV32I core constants: datapath width, reset vector and instruction size.
package core_pkg;

  localparam int unsigned XLEN         = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES  = 4;

endpackage : core_pkg

// File: rtl/program_counter.sv
// IF-stage program counter: loads pc_next every cycle and offers pc + 4 to the next-PC mux.
module program_counter #(
  parameter int unsigned          XLEN         = core_pkg::XLEN,
  parameter logic [XLEN-1:0]      RESET_VECTOR = XLEN'(core_pkg::RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  logic [XLEN-1:0] pc_q;

  // Misaligned targets pass through untouched; exception logic downstream flags them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + XLEN'(core_pkg::INSTR_BYTES);

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed plan items plus randomized loads and resets.
module tb_program_counter;

  localparam logic [31:0] ALT_VECTOR = 32'h0000_1000;

  logic        clk;
  logic        reset;
  logic [31:0] pc_next;
  logic [31:0] pc_a, pc_plus4_a;
  logic [31:0] pc_b, pc_plus4_b;

  typedef struct {
    logic [31:0] pc_a;
    logic [31:0] pc_b;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned tests;
  int unsigned fails;
  logic [31:0] model_pc;
  bit          drive_done;

  program_counter #(.XLEN(32)) dut_a (
    .clk      (clk),
    .reset    (reset),
    .pc_next  (pc_next),
    .pc       (pc_a),
    .pc_plus4 (pc_plus4_a)
  );

  program_counter #(.XLEN(32), .RESET_VECTOR(ALT_VECTOR)) dut_b (
    .clk      (clk),
    .reset    (reset),
    .pc_next  (pc_next),
    .pc       (pc_b),
    .pc_plus4 (pc_plus4_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] plus4(input logic [31:0] v);
    longint unsigned s;
    s = (longint'(v) + 64'd4) % 64'h1_0000_0000;
    return s[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One edge of stimulus; expected post-edge state comes from the reset/load rule.
  task automatic step(input logic rst_n, input logic [31:0] nxt);
    exp_t e;
    @(negedge clk);
    reset   = rst_n;
    pc_next = nxt;
    e.pc_a  = rst_n ? nxt : 32'h0000_0000;
    e.pc_b  = rst_n ? nxt : ALT_VECTOR;
    model_pc = e.pc_a;
    sb_q.push_back(e);
  endtask

  // Reset pulse that lands and clears strictly between two rising edges.
  task automatic glitch_step(input logic [31:0] nxt);
    exp_t e;
    @(negedge clk);
    pc_next = nxt;
    reset   = 1'b0;
    #2;
    reset   = 1'b1;
    e.pc_a  = nxt;
    e.pc_b  = nxt;
    model_pc = nxt;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pc_a",       pc_a,       e.pc_a);
        check("pc_plus4_a", pc_plus4_a, plus4(e.pc_a));
        check("pc_b",       pc_b,       e.pc_b);
        check("pc_plus4_b", pc_plus4_b, plus4(e.pc_b));
      end
    end
  end

  initial begin : driver
    tests = 0;
    fails = 0;
    drive_done = 1'b0;
    reset   = 1'b1;
    pc_next = '0;
    model_pc = '0;

    step(1'b0, 32'd0);
    for (int unsigned i = 1; i <= 5; i++) step(1'b1, 32'(i * 4));
    step(1'b1, 32'd16);
    step(1'b0, 32'd100);
    step(1'b0, 32'd200);
    step(1'b1, 32'd100);
    glitch_step(32'd300);
    step(1'b1, 32'hFFFF_FFFC);
    step(1'b1, 32'h1234_5679);
    for (int unsigned i = 0; i < 3; i++) step(1'b1, model_pc);

    for (int unsigned i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0:       step(1'b0, $urandom);
        1:       glitch_step($urandom);
        2:       step(1'b1, model_pc);
        3:       step(1'b1, 32'hFFFF_FFFC);
        default: step(1'b1, $urandom);
      endcase
    end
    drive_done = 1'b1;
  end

  initial begin : finisher
    int unsigned budget;
    wait (drive_done);
    budget = 0;
    while (sb_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    #2;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule : tb_program_counter

// File: doc/program_counter.md
Name: program_counter

Overview:
- Program-counter register for the RV32I pipelined core. It sits at the head of the IF stage.
- Holds the address of the instruction currently being fetched.
- On each clock edge it loads the next-PC value computed externally by the sequential/branch/jump mux.
- Provides a registered PC and a combinational PC+4 for the next-PC mux.

Parameters:
- XLEN, 32, width of the address datapath in bits.
- RESET_VECTOR, 32'h0000_0000, value loaded into pc while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset. 0 = reset asserted, 1 = run.
- pc_next  input  XLEN  next PC value, already selected by upstream logic.
- pc  output  XLEN  registered current PC.
- pc_plus4  output  XLEN  combinational pc + 4, modulo 2^XLEN.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-low: sampled only on the rising clk edge.
- Asserting or deasserting reset between edges has no effect until the next rising edge.
- Rising edge with reset==0:
  - pc <= RESET_VECTOR.
  - pc_next is ignored.
- Rising edge with reset==1:
  - pc <= pc_next, loaded verbatim with no masking of bits [1:0].
  - Misaligned targets are the exception logic's responsibility.
- Latency: exactly one cycle. pc_next presented before edge N appears on pc immediately after edge N.
- No enable or stall. The register loads every cycle; upstream holds a stall by driving pc_next = pc.
- pc_plus4 = pc + 4, purely combinational from the registered pc.
  - Wraps modulo 2^XLEN, e.g. pc=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000.
  - No carry out.
- Before the first rising edge with reset==0, pc is undefined. Simulation may show X; no power-on value is required.
- Reset mid-operation: the first rising edge with reset==0 forces RESET_VECTOR regardless of pc_next.
  - pc stays at RESET_VECTOR on every edge while reset remains 0.
  - The first edge with reset==1 loads pc_next.
- The output pc is driven directly from the flop, with no combinational path from pc_next to pc.
- pc_plus4 depends only on pc and never on pc_next.
- No latches. Single always block for the register.

Decomposition:
- Shared core package (core_pkg):
  - XLEN = 32.
  - RESET_VECTOR default.
  - INSTR_BYTES = 4, used for the pc_plus4 increment.
- No sub-module. The block is one register plus one adder, implemented flat in program_counter.
- The next-PC mux is a separate block upstream and is not part of this module.

Test Plan:
- Reset: hold reset=0 with pc_next=32'd0 for one edge -> pc=32'h0000_0000 and pc_plus4=32'h0000_0004.
- Sequential load: release reset=1, then drive pc_next = 4, 8, 12, 16, 20 on consecutive cycles -> pc follows one edge later (4, 8, 12, 16, 20) and pc_plus4 = pc+4 each cycle.
- Reset overrides input: pc=32'd16, assert reset=0 with pc_next=32'd100 -> after the edge pc=RESET_VECTOR, not 100. Release reset -> next edge pc=100.
- Synchronous-only reset: pulse reset=0 between two rising edges, deasserted before the next edge -> pc unaffected and loads pc_next normally.
- Wrap-around: pc_next=32'hFFFF_FFFC, one edge -> pc=32'hFFFF_FFFC and pc_plus4=32'h0000_0000.
- Hold and non-default vector: drive pc_next = current pc for 3 cycles -> pc constant. Separately, build with RESET_VECTOR=32'h0000_1000 and reset -> pc=32'h0000_1000.
